// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo path: mode encodings, drain FSM states
// and the push-time case folding rule.
package uart_pkg;

    localparam logic [1:0] MODE_ECHO  = 2'b00;
    localparam logic [1:0] MODE_UPPER = 2'b01;
    localparam logic [1:0] MODE_HOLD  = 2'b10;

    localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_POP,
        DRAIN_LOAD,
        DRAIN_WAIT
    } drain_state_t;

    // Lowercase ASCII is folded to uppercase only in MODE_UPPER; 2'b11 behaves as echo.
    function automatic logic [7:0] fold_case(input logic [1:0] mode, input logic [7:0] b);
        if (mode == MODE_UPPER && b >= 8'h61 && b <= 8'h7A)
            return b - ASCII_CASE_OFFSET;
        return b;
    endfunction

endpackage

// File: rtl/UART_RX.sv
// 8N1 UART receiver. No reset: the line is double-synchronised and the
// state machine falls back to IDLE from any unknown state.
module UART_RX #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   state;
    logic        rx_meta;
    logic        rx_sync;
    logic [15:0] cnt;
    logic [2:0]  idx;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge i_Clock) begin
        rx_meta <= i_RX_Serial;
        rx_sync <= rx_meta;
    end

    // Verify the start bit at mid-bit, then sample each bit at its centre.
    always_ff @(posedge i_Clock) begin
        o_RX_DV <= 1'b0;
        case (state)
            RX_IDLE: begin
                cnt <= '0;
                idx <= '0;
                if (!rx_sync)
                    state <= RX_START;
            end
            RX_START: begin
                if (cnt == 16'((CLKS_PER_BIT-1)/2)) begin
                    cnt   <= '0;
                    state <= rx_sync ? RX_IDLE : RX_DATA;
                end else
                    cnt <= cnt + 16'd1;
            end
            RX_DATA: begin
                if (cnt < 16'(CLKS_PER_BIT-1))
                    cnt <= cnt + 16'd1;
                else begin
                    cnt            <= '0;
                    o_RX_Byte[idx] <= rx_sync;
                    idx            <= idx + 3'd1;
                    if (idx == 3'd7)
                        state <= RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt < 16'(CLKS_PER_BIT-1))
                    cnt <= cnt + 16'd1;
                else begin
                    cnt     <= '0;
                    o_RX_DV <= 1'b1;
                    state   <= RX_IDLE;
                end
            end
            default: state <= RX_IDLE;
        endcase
    end

endmodule

// File: rtl/UART_TX.sv
// 8N1 UART transmitter with synchronous active-low reset. o_TX_Done pulses
// for one cycle as the stop bit completes and o_TX_Active drops.
module UART_TX #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Rst_L,
    input  logic       i_Clock,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done
);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t   state;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  data;

    // Shift out start, eight data bits LSB first, and stop, CLKS_PER_BIT each.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state       <= TX_IDLE;
            cnt         <= '0;
            idx         <= '0;
            data        <= '0;
            o_TX_Active <= 1'b0;
            o_TX_Serial <= 1'b1;
            o_TX_Done   <= 1'b0;
        end else begin
            o_TX_Done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    o_TX_Serial <= 1'b1;
                    cnt         <= '0;
                    idx         <= '0;
                    if (i_TX_DV) begin
                        o_TX_Active <= 1'b1;
                        data        <= i_TX_Byte;
                        state       <= TX_START;
                    end
                end
                TX_START: begin
                    o_TX_Serial <= 1'b0;
                    if (cnt < 16'(CLKS_PER_BIT-1))
                        cnt <= cnt + 16'd1;
                    else begin
                        cnt   <= '0;
                        state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    o_TX_Serial <= data[idx];
                    if (cnt < 16'(CLKS_PER_BIT-1))
                        cnt <= cnt + 16'd1;
                    else begin
                        cnt <= '0;
                        idx <= idx + 3'd1;
                        if (idx == 3'd7)
                            state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    o_TX_Serial <= 1'b1;
                    if (cnt < 16'(CLKS_PER_BIT-1))
                        cnt <= cnt + 16'd1;
                    else begin
                        cnt         <= '0;
                        o_TX_Done   <= 1'b1;
                        o_TX_Active <= 1'b0;
                        state       <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and an occupancy counter.
// A push while full is dropped, even if a pop happens in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge gclk) begin
        if (wr_en)
            mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pop_data <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) begin
                rd_ptr   <= rd_ptr + AW'(1);
                pop_data <= mem[rd_ptr];
            end
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// FIFO-buffered UART echo: received bytes are (optionally) case-folded at
// push time, queued, and drained one at a time into the transmitter.
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    input  logic                        i_UART_RX,
    output logic                        o_UART_TX,
    input  logic [1:0]                  i_Mode,
    input  logic                        i_Clear_Ovf,
    output logic [7:0]                  o_Last_Byte,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
    output logic                        o_Overflow,
    output logic                        o_TX_Busy
);

    drain_state_t state;
    logic         rx_dv;
    logic [7:0]   rx_byte;
    logic [7:0]   push_byte;
    logic [7:0]   fifo_dout;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic         tx_dv;
    logic         tx_active;
    logic         tx_serial;
    logic         tx_done;

    assign push_byte = fold_case(i_Mode, rx_byte);
    assign pop       = (state == DRAIN_POP);
    assign o_TX_Busy = (state != DRAIN_IDLE);
    assign o_UART_TX = tx_active ? tx_serial : 1'b1;

    UART_RX #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_Clock     (i_Clk),
        .i_RX_Serial (i_UART_RX),
        .o_RX_DV     (rx_dv),
        .o_RX_Byte   (rx_byte)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .gclk      (i_Clk),
        .grst_n    (i_Rst_L),
        .push      (rx_dv),
        .push_data (push_byte),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .count     (o_Fifo_Count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    UART_TX #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .i_Rst_L     (i_Rst_L),
        .i_Clock     (i_Clk),
        .i_TX_DV     (tx_dv),
        .i_TX_Byte   (fifo_dout),
        .o_TX_Active (tx_active),
        .o_TX_Serial (tx_serial),
        .o_TX_Done   (tx_done)
    );

    // Raw byte capture and sticky overflow; a drop outranks a same-cycle clear.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            o_Last_Byte <= 8'h00;
            o_Overflow  <= 1'b0;
        end else begin
            if (rx_dv)
                o_Last_Byte <= rx_byte;
            if (rx_dv && fifo_full)
                o_Overflow <= 1'b1;
            else if (i_Clear_Ovf)
                o_Overflow <= 1'b0;
        end
    end

    // Drain FSM: pop one byte, hand it to the transmitter, wait for done.
    // An incoming push also wakes IDLE so a lone byte reaches LOAD two cycles later.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state <= DRAIN_IDLE;
            tx_dv <= 1'b0;
        end else begin
            tx_dv <= (state == DRAIN_POP);
            case (state)
                DRAIN_IDLE: if ((!fifo_empty || rx_dv) && i_Mode != MODE_HOLD) state <= DRAIN_POP;
                DRAIN_POP:  state <= DRAIN_LOAD;
                DRAIN_LOAD: state <= DRAIN_WAIT;
                DRAIN_WAIT: if (tx_done) state <= DRAIN_IDLE;
                default:    state <= DRAIN_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Self-checking bench: serial stimulus on i_UART_RX, a frame monitor on
// o_UART_TX comparing against a scoreboard queue filled at stimulus time.
module tb_uart_echo_buffer;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          i_Clk = 1'b0;
    logic          i_Rst_L = 1'b0;
    logic          i_UART_RX = 1'b1;
    logic          o_UART_TX;
    logic [1:0]    i_Mode = 2'b00;
    logic          i_Clear_Ovf = 1'b0;
    logic [7:0]    o_Last_Byte;
    logic [CW-1:0] o_Fifo_Count;
    logic          o_Overflow;
    logic          o_TX_Busy;

    int            tests = 0;
    int            fails = 0;
    int            rst_epoch = 0;
    int            tx_low_cnt = 0;
    int            lat = 0;
    logic [7:0]    exp_q[$];

    uart_echo_buffer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_UART_RX    (i_UART_RX),
        .o_UART_TX    (o_UART_TX),
        .i_Mode       (i_Mode),
        .i_Clear_Ovf  (i_Clear_Ovf),
        .o_Last_Byte  (o_Last_Byte),
        .o_Fifo_Count (o_Fifo_Count),
        .o_Overflow   (o_Overflow),
        .o_TX_Busy    (o_TX_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    always @(negedge i_Clk) if (o_UART_TX === 1'b0) tx_low_cnt <= tx_low_cnt + 1;

    // Frame monitor: decodes each TX frame at bit centres and pops the scoreboard.
    // Frames interrupted by a reset are discarded.
    initial begin
        logic       prev;
        logic [7:0] b;
        logic [7:0] e;
        logic       stop;
        int         ep;
        prev = 1'b1;
        forever begin
            @(negedge i_Clk);
            if (prev === 1'b1 && o_UART_TX === 1'b0) begin
                ep = rst_epoch;
                repeat (CPB/2) @(negedge i_Clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge i_Clk);
                    b[i] = o_UART_TX;
                end
                repeat (CPB) @(negedge i_Clk);
                stop = o_UART_TX;
                if (ep == rst_epoch) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL tx_unexpected: got %02h expected none", b);
                    end else begin
                        e = exp_q.pop_front();
                        if (b !== e || stop !== 1'b1) begin
                            fails++;
                            $display("FAIL tx_byte: got %02h stop %b expected %02h stop 1", b, stop, e);
                        end
                    end
                end
            end
            prev = o_UART_TX;
        end
    end

    // Drive one 8N1 frame; must be entered at a negedge.
    task automatic uart_send(input logic [7:0] b);
        i_UART_RX = 1'b0;
        repeat (CPB) @(negedge i_Clk);
        for (int i = 0; i < 8; i++) begin
            i_UART_RX = b[i];
            repeat (CPB) @(negedge i_Clk);
        end
        i_UART_RX = 1'b1;
        repeat (CPB) @(negedge i_Clk);
    endtask

    // Send a byte in hold mode and report how many negedges until the count moves.
    task automatic send_measure(input logic [7:0] b, output int k);
        logic [CW-1:0] c0;
        int            kk;
        c0 = o_Fifo_Count;
        kk = -1;
        fork
            uart_send(b);
            begin
                for (int n = 1; n <= 12*CPB; n++) begin
                    @(negedge i_Clk);
                    if (o_Fifo_Count !== c0) begin
                        kk = n;
                        break;
                    end
                end
            end
        join
        k = kk;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && o_TX_Busy === 1'b0 && o_Fifo_Count === '0) && n < 3000) begin
            @(negedge i_Clk);
            n++;
        end
        tests++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL %s_drain: got %0d bytes pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge i_Clk);
    endtask

    task automatic test_reset();
        i_Rst_L = 1'b0;
        repeat (3) @(negedge i_Clk);
        tests += 5;
        if (o_Last_Byte !== 8'h00) begin fails++; $display("FAIL rst_last: got %02h expected 00", o_Last_Byte); end
        if (o_Fifo_Count !== '0) begin fails++; $display("FAIL rst_count: got %0d expected 0", o_Fifo_Count); end
        if (o_Overflow !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b expected 0", o_Overflow); end
        if (o_TX_Busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", o_TX_Busy); end
        if (o_UART_TX !== 1'b1) begin fails++; $display("FAIL rst_tx: got %b expected 1", o_UART_TX); end
        i_Rst_L = 1'b1;
        repeat (20) @(negedge i_Clk);
    endtask

    task automatic test_echo();
        i_Mode = 2'b00;
        exp_q.push_back(8'h41); uart_send(8'h41);
        exp_q.push_back(8'h62); uart_send(8'h62);
        wait_drain("echo");
        tests += 2;
        if (o_Last_Byte !== 8'h62) begin fails++; $display("FAIL echo_last: got %02h expected 62", o_Last_Byte); end
        if (o_Fifo_Count !== '0) begin fails++; $display("FAIL echo_count: got %0d expected 0", o_Fifo_Count); end
    endtask

    task automatic test_upper();
        logic [7:0] tx_in [4];
        logic [7:0] tx_ex [4];
        tx_in = '{8'h61, 8'h7A, 8'h5B, 8'h7B};
        tx_ex = '{8'h41, 8'h5A, 8'h5B, 8'h7B};
        i_Mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(tx_ex[i]);
            uart_send(tx_in[i]);
        end
        wait_drain("upper");
        tests++;
        if (o_Last_Byte !== 8'h7B) begin fails++; $display("FAIL upper_last: got %02h expected 7b (raw)", o_Last_Byte); end
    endtask

    task automatic test_hold_overflow();
        int k;
        int low0;
        i_Mode = 2'b10;
        low0 = tx_low_cnt;
        send_measure(8'h10, lat);
        tests++;
        if (lat < 2) begin fails++; $display("FAIL hold_latency: got %0d expected >=2", lat); end
        for (int i = 1; i < 6; i++) uart_send(8'(8'h10 + i));
        repeat (4) @(negedge i_Clk);
        tests += 5;
        if (o_Fifo_Count !== CW'(DEPTH)) begin fails++; $display("FAIL hold_count: got %0d expected %0d", o_Fifo_Count, DEPTH); end
        if (o_Overflow !== 1'b1) begin fails++; $display("FAIL hold_ovf: got %b expected 1", o_Overflow); end
        if (o_TX_Busy !== 1'b0) begin fails++; $display("FAIL hold_busy: got %b expected 0", o_TX_Busy); end
        if (tx_low_cnt != low0) begin fails++; $display("FAIL hold_txidle: got %0d low cycles expected 0", tx_low_cnt - low0); end
        if (o_Last_Byte !== 8'h15) begin fails++; $display("FAIL hold_last: got %02h expected 15", o_Last_Byte); end
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h10 + i));
        i_Mode = 2'b00;
        wait_drain("hold_release");
        k = 0;
    endtask

    task automatic test_clear_ovf();
        i_Clear_Ovf = 1'b1;
        @(negedge i_Clk);
        i_Clear_Ovf = 1'b0;
        tests++;
        if (o_Overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear_alone: got %b expected 0", o_Overflow); end
        i_Mode = 2'b10;
        for (int i = 0; i < 4; i++) uart_send(8'(8'h20 + i));
        fork
            uart_send(8'h24);
            begin
                repeat (lat - 1) @(negedge i_Clk);
                i_Clear_Ovf = 1'b1;
                @(negedge i_Clk);
                i_Clear_Ovf = 1'b0;
                tests += 2;
                if (o_Overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_wins: got %b expected 1", o_Overflow); end
                if (o_Fifo_Count !== CW'(DEPTH)) begin fails++; $display("FAIL ovf_count: got %0d expected %0d", o_Fifo_Count, DEPTH); end
            end
        join
        i_Clear_Ovf = 1'b1;
        @(negedge i_Clk);
        i_Clear_Ovf = 1'b0;
        tests++;
        if (o_Overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear_after: got %b expected 0", o_Overflow); end
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h20 + i));
        i_Mode = 2'b00;
        wait_drain("ovf_release");
    endtask

    task automatic test_push_pop();
        i_Mode = 2'b10;
        exp_q.push_back(8'h40); uart_send(8'h40);
        exp_q.push_back(8'h41); uart_send(8'h41);
        tests++;
        if (o_Fifo_Count !== CW'(2)) begin fails++; $display("FAIL pp_pre_count: got %0d expected 2", o_Fifo_Count); end
        exp_q.push_back(8'h42);
        fork
            uart_send(8'h42);
            begin
                // Release hold so the POP cycle lines up with the incoming push.
                repeat (lat - 2) @(negedge i_Clk);
                i_Mode = 2'b00;
                @(negedge i_Clk);
                tests++;
                if (o_Fifo_Count !== CW'(2)) begin fails++; $display("FAIL pp_pop_cycle_count: got %0d expected 2", o_Fifo_Count); end
                @(negedge i_Clk);
                tests++;
                if (o_Fifo_Count !== CW'(2)) begin fails++; $display("FAIL pp_same_cycle_count: got %0d expected 2", o_Fifo_Count); end
            end
        join
        wait_drain("push_pop");
    endtask

    task automatic test_reset_mid();
        int n;
        i_Mode = 2'b10;
        uart_send(8'hA5);
        for (int i = 1; i < 4; i++) uart_send(8'(i));
        i_Mode = 2'b00;
        n = 0;
        while (o_UART_TX !== 1'b0 && n < 200) begin
            @(negedge i_Clk);
            n++;
        end
        tests++;
        if (n >= 200) begin fails++; $display("FAIL rm_start: got no start bit expected one"); end
        repeat (3*CPB) @(negedge i_Clk);
        tests++;
        if (o_Fifo_Count !== CW'(3)) begin fails++; $display("FAIL rm_queued: got %0d expected 3", o_Fifo_Count); end
        rst_epoch++;
        i_Rst_L = 1'b0;
        @(negedge i_Clk);
        tests += 4;
        if (o_UART_TX !== 1'b1) begin fails++; $display("FAIL rm_tx: got %b expected 1", o_UART_TX); end
        if (o_Fifo_Count !== '0) begin fails++; $display("FAIL rm_count: got %0d expected 0", o_Fifo_Count); end
        if (o_TX_Busy !== 1'b0) begin fails++; $display("FAIL rm_busy: got %b expected 0", o_TX_Busy); end
        if (o_Last_Byte !== 8'h00) begin fails++; $display("FAIL rm_last: got %02h expected 00", o_Last_Byte); end
        repeat (2) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        repeat (4) @(negedge i_Clk);
        exp_q.push_back(8'h33);
        uart_send(8'h33);
        wait_drain("reset_mid");
        tests++;
        if (o_Last_Byte !== 8'h33) begin fails++; $display("FAIL rm_after_last: got %02h expected 33", o_Last_Byte); end
    endtask

    initial begin
        @(negedge i_Clk);
        test_reset();
        test_echo();
        test_upper();
        test_hold_overflow();
        test_clear_ovf();
        test_push_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
